// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD ripple-counter sampler:
//   BCD_MAX      - largest legal BCD digit
//   filt_state_t - states of the stability filter FSM
//   bcd_to_seg   - active-high {g,f,e,d,c,b,a} pattern for a digit;
//                  codes above 9 return a blank pattern
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        TRACK     = 2'd1,
        ACCEPT    = 2'd2
    } filt_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_sync_filter.sv
// -----------------------------------------------------------------------------
// bcd_sync_filter
// Brings the asynchronous 4-bit ripple-counter value into the i_clk domain and
// accepts a value only after it has been seen on STABLE_CYCLES consecutive
// synchronized samples. Each held value is accepted exactly once.
//
// Ports:
//   i_clk        in   system clock (rising edge)
//   i_rst        in   asynchronous active-high reset
//   i_cnt[3:0]   in   raw counter value, asynchronous, may glitch
//   o_acc_strobe out  one-cycle strobe while the FSM is in ACCEPT
//   o_acc_val    out  accepted value, meaningful while o_acc_strobe = 1
//
// Handshake: o_acc_strobe is a single-cycle valid with no ready; the consumer
// must take o_acc_val in the cycle the strobe is high.
// -----------------------------------------------------------------------------
module bcd_sync_filter
    import bcd_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_cnt,
    output logic       o_acc_strobe,
    output logic [3:0] o_acc_val
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

    logic [3:0]             r_sync [SYNC_STAGES];
    // Tracks how far real samples have travelled down the synchronizer, so
    // reset values in the chain are never mistaken for a counter reading.
    logic [SYNC_STAGES-1:0] r_fill;

    filt_state_t r_state;
    filt_state_t w_state_nxt;
    logic [3:0]  r_cand;
    logic        r_cand_vld;
    logic [3:0]  r_cnt;      // identical samples seen beyond the first
    logic        r_done;     // current candidate already accepted

    logic [3:0] w_s_val;
    logic       w_s_valid;
    logic       w_new;
    logic       w_hold;
    logic       w_fire;
    logic [3:0] w_cnt_nxt;

    assign w_s_val   = r_sync[SYNC_STAGES-1];
    assign w_s_valid = r_fill[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'd0;
            r_fill <= '0;
        end else begin
            r_sync[0] <= i_cnt;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        w_new       = 1'b0;
        w_hold      = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        w_state_nxt = r_state;

        w_new  = w_s_valid && (!r_cand_vld || (w_s_val != r_cand));
        w_hold = w_s_valid && r_cand_vld && (w_s_val == r_cand);

        if (w_new) begin
            w_cnt_nxt = 4'd0;
        end else if (w_hold && (r_cnt != STAB_LAST)) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end

        // Fire on the sample that completes the stability window.
        w_fire = (w_new || (w_hold && !r_done)) && (w_cnt_nxt == STAB_LAST);

        // WAIT_INIT only leaves via ACCEPT; ACCEPT always lasts one cycle.
        if (r_state == ACCEPT) w_state_nxt = TRACK;
        if (w_fire)            w_state_nxt = ACCEPT;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= WAIT_INIT;
            r_cand     <= 4'd0;
            r_cand_vld <= 1'b0;
            r_cnt      <= 4'd0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_new) begin
                r_cand     <= w_s_val;
                r_cand_vld <= 1'b1;
            end
            if (w_fire)     r_done <= 1'b1;
            else if (w_new) r_done <= 1'b0;
        end
    end

    assign o_acc_strobe = (r_state == ACCEPT);
    assign o_acc_val    = r_cand;

endmodule

// File: rtl/bcd_ripple_sampler.sv
// -----------------------------------------------------------------------------
// bcd_ripple_sampler
// Samples a BCD ones digit from an asynchronous mod-10 ripple counter, filters
// ripple transients, extends the count with a tens digit and drives two
// registered 7-segment patterns.
//
// Ports:
//   sys_clk        in   system clock (rising edge)
//   internal_reset in   asynchronous active-high reset
//   cnt_in[3:0]    in   BCD value from the ripple counter (asynchronous)
//   clr_flags      in   single-cycle pulse clearing err_code and skip_flag
//   ones_q[3:0]    out  accepted ones digit
//   tens_q[3:0]    out  tens digit
//   digit_valid    out  high once a first digit has been accepted
//   wrap_pulse     out  one cycle on an accepted 9->0 ones step
//   ovf_pulse      out  one cycle when tens wraps 9->0 (with wrap_pulse)
//   err_code       out  sticky: a code above 9 was accepted by the filter
//   skip_flag      out  sticky: accepted digit was not prev or prev+1 mod 10
//   seg_ones[6:0]  out  {g..a} pattern for ones_q, blank until digit_valid
//   seg_tens[6:0]  out  {g..a} pattern for tens_q, blank until digit_valid
// -----------------------------------------------------------------------------
module bcd_ripple_sampler
    import bcd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       internal_reset,
    input  logic [3:0] cnt_in,
    input  logic       clr_flags,
    output logic [3:0] ones_q,
    output logic [3:0] tens_q,
    output logic       digit_valid,
    output logic       wrap_pulse,
    output logic       ovf_pulse,
    output logic       err_code,
    output logic       skip_flag,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens
);

    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic logic [6:0] seg_drive(input logic [3:0] val);
        return SEG_ACTIVE_LOW ? ~bcd_to_seg(val) : bcd_to_seg(val);
    endfunction

    logic       w_acc_strobe;
    logic [3:0] w_acc_val;

    bcd_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk       (sys_clk),
        .i_rst       (internal_reset),
        .i_cnt       (cnt_in),
        .o_acc_strobe(w_acc_strobe),
        .o_acc_val   (w_acc_val)
    );

    logic [3:0] r_ones, r_tens;
    logic       r_valid, r_wrap, r_ovf, r_err, r_skip;
    logic [6:0] r_seg_ones, r_seg_tens;

    logic       w_take, w_wrap, w_ovf, w_skip_set, w_err_set, w_valid_nxt;
    logic [3:0] w_ones_inc, w_ones_nxt, w_tens_nxt;

    always_comb begin
        w_take      = w_acc_strobe && (w_acc_val <= BCD_MAX);
        w_err_set   = w_acc_strobe && (w_acc_val > BCD_MAX);
        w_ones_inc  = (r_ones == BCD_MAX) ? 4'd0 : r_ones + 4'd1;
        // Step checks only apply once there is a previous digit to compare.
        w_wrap      = w_take && r_valid && (r_ones == BCD_MAX) && (w_acc_val == 4'd0);
        w_ovf       = w_wrap && (r_tens == BCD_MAX);
        w_skip_set  = w_take && r_valid && (w_acc_val != r_ones) && (w_acc_val != w_ones_inc);
        w_ones_nxt  = w_take ? w_acc_val : r_ones;
        w_tens_nxt  = r_tens;
        if (w_wrap) w_tens_nxt = (r_tens == BCD_MAX) ? 4'd0 : r_tens + 4'd1;
        w_valid_nxt = r_valid || w_take;
    end

    always_ff @(posedge sys_clk or posedge internal_reset) begin
        if (internal_reset) begin
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_skip     <= 1'b0;
            r_seg_ones <= SEG_BLANK;
            r_seg_tens <= SEG_BLANK;
        end else begin
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap;
            r_ovf   <= w_ovf;
            // Set beats clear when both happen in the same cycle.
            if (w_err_set)      r_err <= 1'b1;
            else if (clr_flags) r_err <= 1'b0;
            if (w_skip_set)     r_skip <= 1'b1;
            else if (clr_flags) r_skip <= 1'b0;
            // Encoded from next-state digits so segments move with the digits.
            r_seg_ones <= w_valid_nxt ? seg_drive(w_ones_nxt) : SEG_BLANK;
            r_seg_tens <= w_valid_nxt ? seg_drive(w_tens_nxt) : SEG_BLANK;
        end
    end

    assign ones_q      = r_ones;
    assign tens_q      = r_tens;
    assign digit_valid = r_valid;
    assign wrap_pulse  = r_wrap;
    assign ovf_pulse   = r_ovf;
    assign err_code    = r_err;
    assign skip_flag   = r_skip;
    assign seg_ones    = r_seg_ones;
    assign seg_tens    = r_seg_tens;

endmodule
